// File: rtl/data_mem_wait.sv
// Word-addressed data memory with a fixed multi-cycle access time.
// The pipeline holds its request while stall is high; ready (with err) marks completion.
module data_mem_wait #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH     = 1024,
  parameter int    LATENCY   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [DATA_W-1:0] read_data,
  output logic              stall,
  output logic              ready,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_next;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] wdata;
  logic              is_write;
  logic              err_flag;
  logic              req;
  logic              commit;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req    = mem_read | mem_write;
  assign commit = (state == BUSY) && (cnt == 4'd0);

  // Address bits above the word index are deliberately ignored so accesses wrap.
  if (ADDR_W > IDX_W + 2) begin : g_adr_hi
    logic unused_adr_hi;
    assign unused_adr_hi = ^adr[ADDR_W-1:IDX_W+2];
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    ready      = 1'b0;
    err        = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_next = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        err        = err_flag;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      idx       <= '0;
      wdata     <= '0;
      is_write  <= 1'b0;
      err_flag  <= 1'b0;
      read_data <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req) begin
            idx      <= adr[IDX_W+1:2];
            wdata    <= write_data;
            // A dual request is treated as a store and flagged.
            is_write <= mem_write;
            err_flag <= (adr[1:0] != 2'b00) | (mem_read & mem_write);
            cnt      <= 4'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else if (!is_write) read_data <= mem[idx];
        end
        default: ;
      endcase
    end
  end

  // The array has no reset; a store is lost if reset pulls the FSM out of BUSY first.
  always_ff @(posedge clk) begin
    if (commit && is_write) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_data_mem_wait.sv
// Directed self-checking bench for data_mem_wait: LATENCY=3 instance for function,
// LATENCY=1 instance for back-to-back held loads.
module tb_data_mem_wait;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, write_data, read_data;
  logic        mem_read, mem_write, stall, ready, err;
  logic [31:0] adr1, write_data1, read_data1;
  logic        mem_read1, mem_write1, stall1, ready1, err1;

  int   testCount = 0;
  int   failCount = 0;
  int   lat;
  int   stallCnt;
  logic errSeen;
  logic stallDone;

  data_mem_wait #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(3), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .adr(adr), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .read_data(read_data),
    .stall(stall), .ready(ready), .err(err)
  );

  data_mem_wait #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(1), .INIT_FILE("")
  ) dut1 (
    .clk(clk), .rst(rst), .adr(adr1), .write_data(write_data1),
    .mem_read(mem_read1), .mem_write(mem_write1), .read_data(read_data1),
    .stall(stall1), .ready(ready1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one request, holds it until ready, and records latency and stall behaviour.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d);
    @(negedge clk);
    adr = a; write_data = d; mem_read = rd; mem_write = wr;
    @(posedge clk);
    lat = -1; stallCnt = 0; errSeen = 1'b0; stallDone = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready) begin
        lat = n - 1; errSeen = err; stallDone = stall;
        break;
      end
      if (stall) stallCnt++;
    end
    mem_read = 1'b0; mem_write = 1'b0;
    if (lat < 0) checkOutput("ready_timeout", {31'b0, ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int last;
    int pulses;
    rst = 1'b0;
    adr = '0; write_data = '0; mem_read = 1'b0; mem_write = 1'b0;
    adr1 = '0; write_data1 = '0; mem_read1 = 1'b0; mem_write1 = 1'b0;
    #2;
    checkOutput("rst_read_data", read_data, 32'h0);
    checkOutput("rst_ready", {31'b0, ready}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_stall", {31'b0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    checkOutput("st10_latency", lat, 32'd3);
    checkOutput("st10_stall_cycles", stallCnt, 32'd3);
    checkOutput("st10_stall_done", {31'b0, stallDone}, 32'd0);
    checkOutput("st10_err", {31'b0, errSeen}, 32'd0);
    checkOutput("st10_read_data_kept", read_data, 32'h0);
    @(negedge clk);
    checkOutput("st10_ready_one_cycle", {31'b0, ready}, 32'd0);

    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0);
    checkOutput("ld10_latency", lat, 32'd3);
    checkOutput("ld10_read_data", read_data, 32'hDEADBEEF);
    checkOutput("ld10_err", {31'b0, errSeen}, 32'd0);

    applyStimulus(1'b0, 1'b1, 32'h14, 32'h11111111);
    applyStimulus(1'b1, 1'b0, 32'h14, 32'h0);
    checkOutput("ld14_read_data", read_data, 32'h11111111);

    applyStimulus(1'b1, 1'b0, 32'h410, 32'h0);
    checkOutput("ld410_wrap_read_data", read_data, 32'hDEADBEEF);

    applyStimulus(1'b0, 1'b1, 32'h14, 32'h22222222);
    applyStimulus(1'b1, 1'b0, 32'h13, 32'h0);
    checkOutput("ld13_err", {31'b0, errSeen}, 32'd1);
    checkOutput("ld13_read_data", read_data, 32'hDEADBEEF);
    checkOutput("ld13_latency", lat, 32'd3);

    applyStimulus(1'b1, 1'b1, 32'h20, 32'h5);
    checkOutput("dual_err", {31'b0, errSeen}, 32'd1);
    checkOutput("dual_read_data_kept", read_data, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
    checkOutput("ld20_read_data", read_data, 32'h5);
    checkOutput("ld20_err", {31'b0, errSeen}, 32'd0);

    applyStimulus(1'b0, 1'b1, 32'h30, 32'h1234);
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    adr = 32'h30; write_data = 32'h77; mem_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy_stall", {31'b0, stall}, 32'd1);
    mem_write = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("rst_async_read_data", read_data, 32'h0);
    checkOutput("rst_async_stall", {31'b0, stall}, 32'd0);
    checkOutput("rst_async_ready", {31'b0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0);
    checkOutput("rst_discard_read_data", read_data, 32'h1234);

    // LATENCY=1: seed word 0, then hold a load and watch the ready cadence.
    @(negedge clk);
    adr1 = 32'h0; write_data1 = 32'hCAFE; mem_write1 = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ready1) break;
    end
    checkOutput("l1_store_ready", {31'b0, ready1}, 32'd1);
    mem_write1 = 1'b0; mem_read1 = 1'b1;
    last = -1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ready1) begin
        checkOutput("l1_stall_in_done", {31'b0, stall1}, 32'd0);
        checkOutput("l1_read_data", read_data1, 32'hCAFE);
        if (last >= 0) checkOutput("l1_pulse_spacing", k - last, 32'd3);
        last = k;
        pulses++;
      end else begin
        checkOutput("l1_stall_between", {31'b0, stall1}, 32'd1);
      end
    end
    mem_read1 = 1'b0;
    checkOutput("l1_pulse_count", pulses, 32'd4);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
